change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter INIT_COUNT, default 20: the reset coin count for codes 5..15.
REQ-002 The block SHALL have parameter INIT_COUNT_HI, default 0: the reset coin count for codes 1..4.
REQ-003 The block SHALL have parameter CNT_W, default 8: the width of each inventory counter and each plan counter.
REQ-004 Port i_clk, input, 1 bit: the single clock, rising edge.
REQ-005 Port i_rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_money, input, 32 bits: change amount in cents, sampled with i_money_strobe.
REQ-007 Port i_money_strobe, input, 1 bit: change request.
REQ-008 Port i_coin_ack, input, 1 bit: the coin mechanism has taken the presented coin.
REQ-009 Port i_deposit_valid, input, 1 bit: a customer coin has entered the store.
REQ-010 Port i_deposit_code, input, 4 bits: the denomination code of the deposited coin.
REQ-011 Port o_coin, output, 4 bits: the denomination code being dispensed.
REQ-012 Port o_coin_valid, output, 1 bit: o_coin is presented.
REQ-013 Port o_change_ready, output, 1 bit: one-cycle pulse, change fully paid.
REQ-014 Port o_no_money, output, 1 bit: one-cycle pulse, change cannot be paid.
REQ-015 Port o_busy, output, 1 bit: a request is in progress.

Function
REQ-016 The codes SHALL map 1..15 to 50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100, 50, 25, 10, 5, 2, 1 cents; codes 0 and 16 and above are invalid.
REQ-017 The FSM SHALL have states IDLE, PLAN, DISPENSE, DONE and FAIL; the reset state is IDLE.
REQ-018 In IDLE, i_money_strobe=1 SHALL latch i_money into rem, clear all plan counters, set index k=1 and go to PLAN on the next edge.
REQ-019 i_money_strobe in any state other than IDLE SHALL be ignored.
REQ-020 PLAN SHALL do one step per cycle:
- if rem>=value[k] and count[k]>plan[k] and plan[k] is not saturated, increment plan[k] and subtract value[k] from rem;
- otherwise increment k.
REQ-021 When k passes 15 (or rem=0), PLAN SHALL go to DISPENSE if rem=0 and to FAIL otherwise.
REQ-022 A request with i_money=0 SHALL reach DONE with no coins emitted.
REQ-023 DISPENSE SHALL present the lowest code k with plan[k]>0 on o_coin with o_coin_valid=1.
REQ-024 o_coin SHALL hold stable until a cycle with i_coin_ack=1.
REQ-025 On that acknowledge cycle, the block SHALL decrement plan[k] and count[k].
REQ-026 When all plan counters reach 0, the block SHALL go to DONE.
REQ-027 i_coin_ack while o_coin_valid=0 SHALL be ignored.
REQ-028 DONE SHALL pulse o_change_ready for one cycle and then return to IDLE.
REQ-029 FAIL SHALL pulse o_no_money for one cycle, leave inventory unchanged and return to IDLE.
REQ-030 o_busy SHALL be 1 in PLAN, DISPENSE, DONE and FAIL, and 0 in IDLE.
REQ-031 A deposit SHALL be accepted in every state and increment count[code], saturating at 2^CNT_W-1.
REQ-032 An invalid deposit code SHALL be ignored.
REQ-033 A deposit of code k in the same cycle as an acknowledge of code k SHALL leave count[k] unchanged.
REQ-034 Deposits SHALL never alter an active plan.
REQ-035 Latency from strobe to first o_coin_valid SHALL be at most 2+15+(coins planned) cycles.

Reset
REQ-036 While i_rst_n=1 at an edge, all outputs SHALL be 0, the state IDLE, rem and plans 0, and counts set to INIT_COUNT_HI (codes 1..4) or INIT_COUNT (codes 5..15).
REQ-037 Reset mid-request SHALL abort the request with no o_change_ready and no o_no_money pulse; an unacknowledged coin SHALL be withdrawn.

Structure
REQ-038 A shared package SHALL hold the code-to-value table, the state enumeration and CNT_W.
REQ-039 One sub-module, coin_value_rom (code to 32-bit cents, combinational), SHALL be instantiated; the inventory and plan arrays SHALL stay in change_dispenser.

Verification
REQ-040 Reset for 2 cycles SHALL give all outputs 0, o_busy=0 and every count at its INIT value.
REQ-041 i_money=375 with i_coin_ack tied to 1 SHALL produce codes 8, 9, 10, 11, then o_change_ready for 1 cycle; count[8..11] SHALL be 19 afterwards.
REQ-042 i_money=0 SHALL give an o_change_ready pulse, no o_coin_valid, and o_busy for the duration.
REQ-043 i_money=100000 (default inventory total 77860) SHALL give an o_no_money pulse, no coins, and unchanged counts.
REQ-044 i_money=2000 with i_coin_ack low for 10 cycles SHALL keep o_coin=5 and o_coin_valid=1 stable; the acknowledge SHALL then produce o_change_ready.
REQ-045 A deposit of code 8 in the same cycle as the acknowledge of code 8 SHALL leave count[8]=20; reset asserted mid-DISPENSE SHALL clear o_coin_valid with no pulses.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, counter width and
// the denomination code to cent-value table.
package change_dispenser_pkg;

  localparam int CNT_W     = 8;
  localparam int NUM_CODES = 15;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    DISPENSE,
    DONE,
    FAIL
  } state_t;

  // Code 0 and anything above 15 map to zero cents (invalid denomination).
  function automatic logic [31:0] coin_value(input logic [4:0] code);
    case (code)
      5'd1:    coin_value = 32'd50000;
      5'd2:    coin_value = 32'd20000;
      5'd3:    coin_value = 32'd10000;
      5'd4:    coin_value = 32'd5000;
      5'd5:    coin_value = 32'd2000;
      5'd6:    coin_value = 32'd1000;
      5'd7:    coin_value = 32'd500;
      5'd8:    coin_value = 32'd200;
      5'd9:    coin_value = 32'd100;
      5'd10:   coin_value = 32'd50;
      5'd11:   coin_value = 32'd25;
      5'd12:   coin_value = 32'd10;
      5'd13:   coin_value = 32'd5;
      5'd14:   coin_value = 32'd2;
      5'd15:   coin_value = 32'd1;
      default: coin_value = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_rom.sv
// Combinational lookup from a 4-bit denomination code to its value in cents.
module coin_value_rom
  import change_dispenser_pkg::*;
(
  input  logic [3:0]  code,
  output logic [31:0] value
);

  assign value = coin_value({1'b0, code});

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: plans coins largest-first against the inventory,
// then hands them out one at a time under coin-mechanism handshake.
module change_dispenser #(
  parameter int INIT_COUNT    = 20,
  parameter int INIT_COUNT_HI = 0,
  parameter int CNT_W         = change_dispenser_pkg::CNT_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_money,
  input  logic        i_money_strobe,
  input  logic        i_coin_ack,
  input  logic        i_deposit_valid,
  input  logic [3:0]  i_deposit_code,
  output logic [3:0]  o_coin,
  output logic        o_coin_valid,
  output logic        o_change_ready,
  output logic        o_no_money,
  output logic        o_busy
);
  import change_dispenser_pkg::*;

  state_t           state_reg, state_next;
  logic [31:0]      rem_reg, rem_next;
  logic [4:0]       k_reg, k_next;
  logic [CNT_W-1:0] plan_reg  [16];
  logic [CNT_W-1:0] count_reg [16];

  logic [3:0]  k_idx;
  logic [31:0] k_value;
  logic [3:0]  disp_code;
  logic        disp_any;
  logic        plan_take;
  logic        plan_clear;
  logic        ack_fire;
  logic [15:1] dep_hit;
  logic [15:1] ack_hit;

  assign k_idx = k_reg[3:0];

  coin_value_rom u_rom (
    .code  (k_idx),
    .value (k_value)
  );

  // Lowest code with coins still owed; descending scan so the lowest wins.
  always_comb begin
    disp_code = 4'd0;
    disp_any  = 1'b0;
    for (int i = 15; i >= 1; i--) begin
      if (plan_reg[i] != '0) begin
        disp_code = 4'(i);
        disp_any  = 1'b1;
      end
    end
  end

  assign plan_clear = (state_reg == IDLE) && i_money_strobe;
  assign plan_take  = (state_reg == PLAN) && (rem_reg != 32'd0) && !k_reg[4] &&
                      (rem_reg >= k_value) &&
                      (count_reg[k_idx] > plan_reg[k_idx]) &&
                      (plan_reg[k_idx] != '1);
  assign ack_fire   = (state_reg == DISPENSE) && disp_any && i_coin_ack;

  for (genvar gi = 1; gi < 16; gi++) begin : g_hit
    assign dep_hit[gi] = i_deposit_valid && (i_deposit_code == 4'(gi));
    assign ack_hit[gi] = ack_fire && (disp_code == 4'(gi));
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    k_next         = k_reg;
    o_coin         = 4'd0;
    o_coin_valid   = 1'b0;
    o_change_ready = 1'b0;
    o_no_money     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_money_strobe) begin
          rem_next   = i_money;
          k_next     = 5'd1;
          state_next = PLAN;
        end
      end
      PLAN: begin
        if (rem_reg == 32'd0)  state_next = DISPENSE;
        else if (k_reg[4])     state_next = FAIL;
        else if (plan_take)    rem_next   = rem_reg - k_value;
        else                   k_next     = k_reg + 5'd1;
      end
      DISPENSE: begin
        if (disp_any) begin
          o_coin       = disp_code;
          o_coin_valid = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_change_ready = 1'b1;
        state_next     = IDLE;
      end
      FAIL: begin
        o_no_money = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state_reg != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      k_reg     <= '0;
      for (int i = 0; i < 16; i++) begin
        plan_reg[i] <= '0;
        if (i == 0)      count_reg[i] <= '0;
        else if (i <= 4) count_reg[i] <= CNT_W'(INIT_COUNT_HI);
        else             count_reg[i] <= CNT_W'(INIT_COUNT);
      end
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      k_reg     <= k_next;
      for (int i = 1; i < 16; i++) begin
        if (plan_clear)
          plan_reg[i] <= '0;
        else if (plan_take && (k_idx == 4'(i)))
          plan_reg[i] <= plan_reg[i] + 1'b1;
        else if (ack_hit[i])
          plan_reg[i] <= plan_reg[i] - 1'b1;
        // A deposit and a payout of the same code cancel out.
        if (dep_hit[i] && !ack_hit[i] && (count_reg[i] != '1))
          count_reg[i] <= count_reg[i] + 1'b1;
        else if (ack_hit[i] && !dep_hit[i])
          count_reg[i] <= count_reg[i] - 1'b1;
      end
    end
  end

endmodule
